// File: rtl/alu_ctrl_pipe.sv
// alu_ctrl_pipe: ALU controller between issue and the SIMD/SIMF VALU.
// Decodes source operand addresses into read enables and mux selects, buffers up
// to DEPTH instructions (RD stage + FIFO) so operand read overlaps execution,
// starts the VALU on the FIFO head and retires instructions strictly in order.
// Ports:
//   clk, rst_n                 clock (rising edge), async active-low reset
//   in_alu_select/out_alu_ready issue handshake
//   in_source_addr, in_dest*   operand / destination addresses (12 bit each)
//   in_opcode, in_dec_*_wr_en  decoded instruction payload
//   in_valu_done               VALU result valid
//   out_*_rd_en                register-file read enables (combinational, accept cycle)
//   out_source_*               registered operand mux selects / constants (RD stage)
//   out_alu_start/control      VALU start pulse and opcode while executing
//   out_*_dest_addr, *_wr_en, out_instr_done  writeback strobes
//   out_inflight               RD + FIFO occupancy
module alu_ctrl_pipe #(
   parameter int unsigned NUM_SRC  = 3,
   parameter int unsigned DEPTH    = 2,
   parameter int unsigned OPCODE_W = 32
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    in_alu_select,
   output logic                    out_alu_ready,
   input  logic [12*NUM_SRC-1:0]   in_source_addr,
   input  logic [11:0]             in_dest1_addr,
   input  logic [11:0]             in_dest2_addr,
   input  logic [OPCODE_W-1:0]     in_opcode,
   input  logic                    in_dec_vcc_wr_en,
   input  logic                    in_dec_vgpr_wr_en,
   input  logic                    in_dec_sgpr_wr_en,
   input  logic                    in_valu_done,
   output logic [NUM_SRC-1:0]      out_vgpr_source_rd_en,
   output logic                    out_sgpr_rd_en,
   output logic                    out_exec_rd_en,
   output logic                    out_src_buffer_wr_en,
   output logic [4*NUM_SRC-1:0]    out_source_mux_select,
   output logic [10*NUM_SRC-1:0]   out_source_src_constant,
   output logic                    out_alu_start,
   output logic [OPCODE_W-1:0]     out_alu_control,
   output logic [11:0]             out_vgpr_dest_addr,
   output logic [11:0]             out_sgpr_dest_addr,
   output logic                    out_vgpr_wr_en,
   output logic                    out_sgpr_wr_en,
   output logic                    out_vcc_wr_en,
   output logic                    out_instr_done,
   output logic [3:0]              out_inflight
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_START = 2'd1;
   localparam logic [1:0] S_WAIT  = 2'd2;
   localparam logic [1:0] S_WB    = 2'd3;

   typedef struct packed {
      logic [OPCODE_W-1:0] opcode;
      logic [11:0]         vgpr_dest;
      logic [11:0]         sgpr_dest;
      logic                vgpr_wr_en;
      logic                sgpr_wr_en;
      logic                vcc_wr_en;
   } entry_t;

   // Operand source class; unknown encodings map to 4'hF, never X.
   function automatic logic [3:0] src_sel(input logic [11:0] a);
      logic [3:0] s;
      s = 4'hF;
      if (a == 12'h7FF)              s = 4'd0;
      else if (a[11:10] == 2'b00)    s = 4'd1;
      else if (a[11:10] == 2'b10)    s = 4'd2;
      else if (a[11:9] == 3'b110)    s = 4'd3;
      else begin
         case (a)
            12'hE01: s = 4'd4;
            12'hE02: s = 4'd5;
            12'hE04: s = 4'd6;
            12'hE08: s = 4'd7;
            12'hE10: s = 4'd8;
            12'hE20: s = 4'd9;
            12'hE40: s = 4'd10;
            12'hE80: s = 4'd11;
            default: s = 4'hF;
         endcase
      end
      return s;
   endfunction

   // Circular pointer increment (DEPTH need not be a power of two).
   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (32'(p) == DEPTH - 1) ? '0 : p + PTR_W'(1);
   endfunction

   logic [1:0]            state_q, state_d;
   logic                  rd_valid_q, rd_valid_d;
   entry_t                rd_entry_q, rd_entry_d;
   entry_t                exec_q, exec_d;
   entry_t                fifo_mem [DEPTH];
   entry_t                head_nxt;
   logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]      fifo_cnt_q, fifo_cnt_d, occupancy;
   logic [4*NUM_SRC-1:0]  mux_sel_q, mux_sel_d;
   logic [10*NUM_SRC-1:0] src_const_q, src_const_d;
   logic                  alu_start_q, alu_start_d;
   logic [OPCODE_W-1:0]   alu_control_q, alu_control_d;
   logic [11:0]           vgpr_dest_q, vgpr_dest_d, sgpr_dest_q, sgpr_dest_d;
   logic                  vgpr_wr_en_q, vgpr_wr_en_d;
   logic                  sgpr_wr_en_q, sgpr_wr_en_d;
   logic                  vcc_wr_en_q, vcc_wr_en_d;
   logic                  instr_done_q, instr_done_d;
   logic                  accept, push, pop, dest_swap;

   // Issue handshake and accept-cycle read enables.
   always_comb begin
      occupancy     = fifo_cnt_q + CNT_W'(rd_valid_q);
      out_alu_ready = rst_n && (32'(occupancy) < DEPTH);
      accept        = in_alu_select && out_alu_ready;
      for (int unsigned n = 0; n < NUM_SRC; n++) begin
         out_vgpr_source_rd_en[n] = accept && (in_source_addr[12*n+10 +: 2] == 2'b10);
      end
      out_sgpr_rd_en = accept;
      out_exec_rd_en = accept;
   end

   // RD stage capture and FIFO bookkeeping.
   always_comb begin
      mux_sel_d   = mux_sel_q;
      src_const_d = src_const_q;
      rd_valid_d  = accept;
      rd_entry_d  = rd_entry_q;
      // A VGPR-class dest goes to the VGPR port; otherwise an SGPR-class dest1 or
      // a VGPR-class dest2 forces the swap.
      dest_swap   = (in_dest1_addr[11:10] == 2'b11) ||
                    ((in_dest1_addr[11:10] != 2'b10) && (in_dest2_addr[11:10] == 2'b10));
      if (accept) begin
         for (int unsigned n = 0; n < NUM_SRC; n++) begin
            mux_sel_d[4*n +: 4]    = src_sel(in_source_addr[12*n +: 12]);
            src_const_d[10*n +: 10] = in_source_addr[12*n +: 10];
         end
         rd_entry_d.opcode     = in_opcode;
         rd_entry_d.vgpr_dest  = dest_swap ? in_dest2_addr : in_dest1_addr;
         rd_entry_d.sgpr_dest  = dest_swap ? in_dest1_addr : in_dest2_addr;
         rd_entry_d.vgpr_wr_en = in_dec_vgpr_wr_en;
         rd_entry_d.sgpr_wr_en = in_dec_sgpr_wr_en;
         rd_entry_d.vcc_wr_en  = in_dec_vcc_wr_en;
      end
      push       = rd_valid_q;
      pop        = (state_q == S_WB);
      wr_ptr_d   = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
      rd_ptr_d   = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
      fifo_cnt_d = fifo_cnt_q + CNT_W'(push) - CNT_W'(pop);
   end

   // Execute FSM; outputs are registered from the next state.
   always_comb begin
      state_d       = state_q;
      exec_d        = exec_q;
      alu_start_d   = 1'b0;
      alu_control_d = '0;
      instr_done_d  = 1'b0;
      vgpr_dest_d   = '0;
      sgpr_dest_d   = '0;
      vgpr_wr_en_d  = 1'b0;
      sgpr_wr_en_d  = 1'b0;
      vcc_wr_en_d   = 1'b0;
      // In WB the current head is being popped, so the next one sits one slot on.
      head_nxt      = (state_q == S_WB) ? fifo_mem[ptr_inc(rd_ptr_q)] : fifo_mem[rd_ptr_q];
      case (state_q)
         S_IDLE:  if (fifo_cnt_q != '0) state_d = S_START;
         S_START: state_d = in_valu_done ? S_WB : S_WAIT;
         S_WAIT:  if (in_valu_done) state_d = S_WB;
         S_WB:    state_d = (fifo_cnt_q > CNT_W'(1)) ? S_START : S_IDLE;
         default: state_d = S_IDLE;
      endcase
      if (state_d == S_START) exec_d = head_nxt;
      alu_start_d = (state_d == S_START);
      if ((state_d == S_START) || (state_d == S_WAIT)) alu_control_d = exec_d.opcode;
      if (state_d == S_WB) begin
         instr_done_d = 1'b1;
         vgpr_dest_d  = exec_d.vgpr_dest;
         sgpr_dest_d  = exec_d.sgpr_dest;
         vgpr_wr_en_d = exec_d.vgpr_wr_en;
         sgpr_wr_en_d = exec_d.sgpr_wr_en;
         vcc_wr_en_d  = exec_d.vcc_wr_en;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= S_IDLE;
         rd_valid_q    <= 1'b0;
         rd_entry_q    <= '0;
         exec_q        <= '0;
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         fifo_cnt_q    <= '0;
         mux_sel_q     <= '0;
         src_const_q   <= '0;
         alu_start_q   <= 1'b0;
         alu_control_q <= '0;
         vgpr_dest_q   <= '0;
         sgpr_dest_q   <= '0;
         vgpr_wr_en_q  <= 1'b0;
         sgpr_wr_en_q  <= 1'b0;
         vcc_wr_en_q   <= 1'b0;
         instr_done_q  <= 1'b0;
      end else begin
         state_q       <= state_d;
         rd_valid_q    <= rd_valid_d;
         rd_entry_q    <= rd_entry_d;
         exec_q        <= exec_d;
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         fifo_cnt_q    <= fifo_cnt_d;
         mux_sel_q     <= mux_sel_d;
         src_const_q   <= src_const_d;
         alu_start_q   <= alu_start_d;
         alu_control_q <= alu_control_d;
         vgpr_dest_q   <= vgpr_dest_d;
         sgpr_dest_q   <= sgpr_dest_d;
         vgpr_wr_en_q  <= vgpr_wr_en_d;
         sgpr_wr_en_q  <= sgpr_wr_en_d;
         vcc_wr_en_q   <= vcc_wr_en_d;
         instr_done_q  <= instr_done_d;
      end
   end

   // FIFO storage holds payload only; validity is tracked by the pointers/count.
   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr_q] <= rd_entry_q;
   end

   assign out_src_buffer_wr_en    = rd_valid_q;
   assign out_source_mux_select   = mux_sel_q;
   assign out_source_src_constant = src_const_q;
   assign out_alu_start           = alu_start_q;
   assign out_alu_control         = alu_control_q;
   assign out_vgpr_dest_addr      = vgpr_dest_q;
   assign out_sgpr_dest_addr      = sgpr_dest_q;
   assign out_vgpr_wr_en          = vgpr_wr_en_q;
   assign out_sgpr_wr_en          = sgpr_wr_en_q;
   assign out_vcc_wr_en           = vcc_wr_en_q;
   assign out_instr_done          = instr_done_q;
   assign out_inflight            = 4'(occupancy);

endmodule
